noise_burst_scheduler: RTL

- Arbitrates one shared 16-bit LFSR noise source among NUM_REQ requesters, e.g. DAE training-data mixers and the per-channel noise injectors of the hearing-aid datapath.
- Round-robin arbitration grants whole bursts of REQ length.
- Each burst delivers scaled signed noise samples over a valid/ready stream tagged with the requester ID.
- The LFSR advances only on accepted samples, so the noise sequence is deterministic and reproducible regardless of consumer stalls.

---
 rtl/noise_burst_scheduler.sv | 119 +++++++++++
 1 files changed

// File: rtl/noise_burst_scheduler.sv
// Round-robin scheduler that hands out bursts of scaled LFSR noise to NUM_REQ requesters.
// The LFSR only steps on accepted samples, so the sequence is independent of consumer stalls.
module noise_burst_scheduler #(
  parameter int          NUM_REQ = 4,
  parameter int          BURST_W = 8,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [2:0]                 cfg_shift,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*BURST_W-1:0] req_len,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic                       noise_valid,
  input  logic                       noise_ready,
  output logic [7:0]                 noise_data,
  output logic [$clog2(NUM_REQ)-1:0] noise_id,
  output logic                       noise_last
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state;
  logic [15:0]        lfsr;
  logic [15:0]        lfsr_next;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     winner;
  logic               found;
  logic [BURST_W-1:0] count;
  logic [BURST_W-1:0] win_len;
  logic [BURST_W-1:0] eff_len;
  logic [2:0]         shift_q;

  function automatic logic [7:0] scale(input logic [7:0] raw, input logic [2:0] sh);
    return $signed(raw) >>> sh;
  endfunction

  always_comb lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Search upward from the round-robin pointer, wrapping, for the first active request.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin
    win_len = req_len[winner*BURST_W +: BURST_W];
    eff_len = (win_len == '0) ? BURST_W'(1) : win_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= SEED;
      ptr         <= '0;
      count       <= '0;
      shift_q     <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      noise_valid <= 1'b0;
      noise_data  <= '0;
      noise_id    <= '0;
      noise_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          grant <= '0;
          if (en && found) begin
            state       <= BURST;
            grant       <= NUM_REQ'(1) << winner;
            busy        <= 1'b1;
            noise_valid <= 1'b1;
            noise_id    <= winner;
            count       <= eff_len;
            noise_last  <= (eff_len == BURST_W'(1));
            shift_q     <= cfg_shift;
            noise_data  <= scale(lfsr[7:0], cfg_shift);
            ptr         <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          end
        end
        BURST: begin
          grant <= '0;
          if (noise_valid && noise_ready) begin
            lfsr <= lfsr_next;
            if (noise_last) begin
              // Burst done: drop everything for one mandatory idle cycle.
              state       <= IDLE;
              busy        <= 1'b0;
              noise_valid <= 1'b0;
              noise_last  <= 1'b0;
              noise_data  <= '0;
              count       <= '0;
            end else begin
              count      <= count - 1'b1;
              noise_last <= (count == BURST_W'(2));
              noise_data <= scale(lfsr_next[7:0], shift_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
